// File: rtl/encoder_8_3.sv
// -----------------------------------------------------------------------------
// encoder_8_3
//
// Registered 8-to-3 priority encoder. Each rising edge of CP samples the
// request vector DATA and loads the index of its highest-numbered set bit into
// outcomes. valid is loaded with 1 when any request bit was set.
//
// DATA = 8'h00 loads outcomes = 3'd0 with valid = 0. This result differs from a
// lone DATA[0] request only in valid.
//
// There is one register stage and no input register. There is no enable, so
// the outputs reload on every rising edge. Both outputs come directly from
// flops, so they do not glitch between edges.
//
// Ports (declaration order is fixed; existing instances connect the first
// three ports by position):
//   CP        in   1  system clock; all state updates on the rising edge
//   DATA      in   8  request vector; bit i set means request i is asserted
//   outcomes  out  3  registered index of the highest set bit of DATA
//   RST_n     in   1  asynchronous active-low reset; clears outcomes and valid
//   valid     out  1  registered; 1 when DATA was non-zero at the last edge
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module encoder_8_3 (
  input  logic       CP,
  input  logic [7:0] DATA,
  output logic [2:0] outcomes,
  input  logic       RST_n,
  output logic       valid
);

  // Priority compression: the highest set bit wins. For an all-zero vector the
  // function returns 3'd0, and valid distinguishes that case from a DATA[0]
  // request.
  function automatic logic [2:0] prio_index(input logic [7:0] req);
    logic [2:0] idx;
    casez (req)
      8'b1???????: idx = 3'd7;
      8'b01??????: idx = 3'd6;
      8'b001?????: idx = 3'd5;
      8'b0001????: idx = 3'd4;
      8'b00001???: idx = 3'd3;
      8'b000001??: idx = 3'd2;
      8'b0000001?: idx = 3'd1;
      8'b00000001: idx = 3'd0;
      default:     idx = 3'd0;
    endcase
    return idx;
  endfunction

  logic [2:0] w_index;
  logic       w_any;
  logic [2:0] r_outcomes;
  logic       r_valid;

  // Combinational encode of the current request vector
  always_comb begin
    w_index = 3'd0;
    w_any   = 1'b0;
    w_index = prio_index(DATA);
    w_any   = |DATA;
  end

  // Output register stage, cleared asynchronously by RST_n
  always_ff @(posedge CP or negedge RST_n) begin
    if (!RST_n) begin
      r_outcomes <= 3'd0;
      r_valid    <= 1'b0;
    end else begin
      r_outcomes <= w_index;
      r_valid    <= w_any;
    end
  end

  assign outcomes = r_outcomes;
  assign valid    = r_valid;

endmodule

// File: tb/tb_encoder_8_3.sv
`timescale 1ns/100ps

module tb_encoder_8_3;

  logic       CP;
  logic [7:0] DATA;
  logic [2:0] outcomes;
  logic       RST_n;
  logic       valid;

  int n_checks;
  int n_pass;

  encoder_8_3 dut (
    .CP       (CP),
    .DATA     (DATA),
    .outcomes (outcomes),
    .RST_n    (RST_n),
    .valid    (valid)
  );

  // 2 ns clock period; rising edges fall at odd ns
  initial begin
    CP = 1'b0;
    forever #1 CP = ~CP;
  end

  task automatic test_reset();
    RST_n = 1'b0;
    DATA  = 8'h80;
    #0.3;
    n_checks++;
    if (outcomes !== 3'd0) $display("FAIL reset_immediate_outcomes: got %0d expected 0", outcomes);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL reset_immediate_valid: got %b expected 0", valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge CP); #0.5;
      n_checks++;
      if (outcomes !== 3'd0 || valid !== 1'b0)
        $display("FAIL reset_hold: cycle %0d got outcomes=%0d valid=%b expected 0/0", i, outcomes, valid);
      else n_pass++;
    end
    @(negedge CP);
    RST_n = 1'b1;
    #0.5;
    n_checks++;
    if (outcomes !== 3'd0 || valid !== 1'b0)
      $display("FAIL reset_release_before_edge: got outcomes=%0d valid=%b expected 0/0", outcomes, valid);
    else n_pass++;
    @(posedge CP); #0.5;
    n_checks++;
    if (outcomes !== 3'd7) $display("FAIL reset_release_outcomes: got %0d expected 7", outcomes);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b1) $display("FAIL reset_release_valid: got %b expected 1", valid);
    else n_pass++;
  endtask

  task automatic test_one_hot();
    logic [7:0] vec;
    for (int i = 0; i < 8; i++) begin
      @(negedge CP);
      vec  = 8'h01 << i;
      DATA = vec;
      @(posedge CP); #0.5;
      n_checks++;
      if (outcomes !== 3'(i) || valid !== 1'b1)
        $display("FAIL one_hot_first_edge: DATA=%h got outcomes=%0d valid=%b expected %0d/1", vec, outcomes, valid, i);
      else n_pass++;
      // hold for the rest of the 10 ns window and confirm the value is stable
      repeat (4) @(posedge CP);
      #0.5;
      n_checks++;
      if (outcomes !== 3'(i) || valid !== 1'b1)
        $display("FAIL one_hot_hold: DATA=%h got outcomes=%0d valid=%b expected %0d/1", vec, outcomes, valid, i);
      else n_pass++;
    end
  endtask

  task automatic test_priority();
    logic [7:0] vecs [4];
    logic [2:0] exps [4];
    vecs[0] = 8'h05; exps[0] = 3'd2;
    vecs[1] = 8'h81; exps[1] = 3'd7;
    vecs[2] = 8'h7E; exps[2] = 3'd6;
    vecs[3] = 8'hFF; exps[3] = 3'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge CP);
      DATA = vecs[i];
      @(posedge CP); #0.5;
      n_checks++;
      if (outcomes !== exps[i] || valid !== 1'b1)
        $display("FAIL priority: DATA=%h got outcomes=%0d valid=%b expected %0d/1", vecs[i], outcomes, valid, exps[i]);
      else n_pass++;
    end
  endtask

  task automatic test_zero();
    @(negedge CP);
    DATA = 8'h00;
    @(posedge CP); #0.5;
    n_checks++;
    if (outcomes !== 3'd0) $display("FAIL zero_outcomes: got %0d expected 0", outcomes);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL zero_valid: got %b expected 0", valid);
    else n_pass++;
    @(negedge CP);
    DATA = 8'h01;
    @(posedge CP); #0.5;
    n_checks++;
    if (outcomes !== 3'd0) $display("FAIL zero_then_bit0_outcomes: got %0d expected 0", outcomes);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b1) $display("FAIL zero_then_bit0_valid: got %b expected 1", valid);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge CP);
    DATA = 8'h20;
    @(posedge CP); #0.5;
    n_checks++;
    if (outcomes !== 3'd5 || valid !== 1'b1)
      $display("FAIL async_pre: got outcomes=%0d valid=%b expected 5/1", outcomes, valid);
    else n_pass++;
    // pulse reset entirely between a falling and the next rising edge
    @(negedge CP);
    #0.3 RST_n = 1'b0;
    #0.2;
    n_checks++;
    if (outcomes !== 3'd0 || valid !== 1'b0)
      $display("FAIL async_clear: got outcomes=%0d valid=%b expected 0/0", outcomes, valid);
    else n_pass++;
    #0.2 RST_n = 1'b1;
    #0.1;
    n_checks++;
    if (outcomes !== 3'd0 || valid !== 1'b0)
      $display("FAIL async_after_release: got outcomes=%0d valid=%b expected 0/0", outcomes, valid);
    else n_pass++;
    @(posedge CP); #0.5;
    n_checks++;
    if (outcomes !== 3'd5 || valid !== 1'b1)
      $display("FAIL async_resume: got outcomes=%0d valid=%b expected 5/1", outcomes, valid);
    else n_pass++;
  endtask

  task automatic test_latency();
    @(negedge CP);
    DATA = 8'h08;
    @(posedge CP); #0.5;
    n_checks++;
    if (outcomes !== 3'd3) $display("FAIL latency_setup: got %0d expected 3", outcomes);
    else n_pass++;
    // 0.5 ns after that edge, change DATA and check the output holds
    DATA = 8'h40;
    #0.4;
    n_checks++;
    if (outcomes !== 3'd3) $display("FAIL latency_hold: got %0d expected 3", outcomes);
    else n_pass++;
    @(negedge CP); #0.5;
    n_checks++;
    if (outcomes !== 3'd3) $display("FAIL latency_hold_late: got %0d expected 3", outcomes);
    else n_pass++;
    @(posedge CP); #0.5;
    n_checks++;
    if (outcomes !== 3'd6 || valid !== 1'b1)
      $display("FAIL latency_update: got outcomes=%0d valid=%b expected 6/1", outcomes, valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vecs [6];
    logic [2:0] exps [6];
    logic       vals [6];
    vecs[0] = 8'h30; exps[0] = 3'd5; vals[0] = 1'b1;
    vecs[1] = 8'h00; exps[1] = 3'd0; vals[1] = 1'b0;
    vecs[2] = 8'h0C; exps[2] = 3'd3; vals[2] = 1'b1;
    vecs[3] = 8'h02; exps[3] = 3'd1; vals[3] = 1'b1;
    vecs[4] = 8'hC0; exps[4] = 3'd7; vals[4] = 1'b1;
    vecs[5] = 8'h13; exps[5] = 3'd4; vals[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CP);
      DATA = vecs[i];
      @(posedge CP); #0.5;
      n_checks++;
      if (outcomes !== exps[i] || valid !== vals[i])
        $display("FAIL back_to_back: DATA=%h got outcomes=%0d valid=%b expected %0d/%b",
                 vecs[i], outcomes, valid, exps[i], vals[i]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    RST_n    = 1'b0;
    DATA     = 8'h00;
    test_reset();
    test_one_hot();
    test_priority();
    test_zero();
    test_async_reset();
    test_latency();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
